mem_access_ctrl: RTL and testbench

- Sequencing and arbitration controller in front of the word-addressed data memory.
- Memory interface: combinational read, write on negedge clk, address shifted right by 2 internally.
- Shares the memory between two requesters: port A (CPU load/store unit) and port B (program loader/debug).
- Adds byte-enable stores by read-modify-write and returns registered read data with a one-cycle ack pulse.

---
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Two-port round-robin front end for the word-addressed data memory: loads, full stores,
// and byte-enable stores by read-modify-write. Optional MEM_CTRL_RANGE_CHECK_EN flags out-of-window accesses.
module mem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h7FFFFBFC,
   parameter logic [31:0] TOP_ADDR  = 32'h7FFFFFFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        aReq,
   input  logic        aWe,
   input  logic [31:0] aAddr,
   input  logic [31:0] aWdata,
   input  logic [3:0]  aBe,
   output logic        aAck,
   output logic [31:0] aRdata,
   input  logic        bReq,
   input  logic        bWe,
   input  logic [31:0] bAddr,
   input  logic [31:0] bWdata,
   input  logic [3:0]  bBe,
   output logic        bAck,
   output logic [31:0] bRdata,
   output logic        err,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData
);

   // state | meaning
   // IDLE  | arbitrate, latch winner's request
   // READ  | memory read, capture load data
   // MERGE | memory read, build merged word for partial store
   // WRITE | memory write (commits on negedge)
   // RESP  | one-cycle ack to the winner
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_MERGE,
      ST_WRITE,
      ST_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;       // 1: port B preferred on a tie
   logic        win_q, win_d;       // 1: port B owns the transaction
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        err_q, err_d;
   logic [31:0] a_rdata_q, a_rdata_d;
   logic [31:0] b_rdata_q, b_rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        gnt_b;
   logic        req_we;
   logic [31:0] raw_addr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        out_of_range;
   logic        skip_mem;
   logic [31:0] merged;
   logic        unused_addr_bits;

   assign gnt_b     = bReq && (!aReq || ptr_q);
   assign req_we    = gnt_b ? bWe    : aWe;
   assign raw_addr  = gnt_b ? bAddr  : aAddr;
   assign req_wdata = gnt_b ? bWdata : aWdata;
   assign req_be    = gnt_b ? bBe    : aBe;
   assign req_addr  = {raw_addr[31:2], 2'b00};
   assign unused_addr_bits = ^raw_addr[1:0];

   assign out_of_range = (req_addr < BASE_ADDR) || (req_addr > TOP_ADDR);

`ifdef MEM_CTRL_RANGE_CHECK_EN
   assign skip_mem = out_of_range;
`else
   logic unused_range;
   assign unused_range = out_of_range;
   assign skip_mem     = 1'b0;
`endif

   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : memReadData[8*i +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      err_d       = err_q;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (aReq || bReq) begin
               win_d   = gnt_b;
               ptr_d   = ~gnt_b;
               wdata_d = req_wdata;
               be_d    = req_be;
               err_d   = skip_mem;
               if (skip_mem) begin
                  state_d = ST_RESP;
                  if (!req_we) begin
                     if (gnt_b) b_rdata_d = '0;
                     else       a_rdata_d = '0;
                  end
               end else if (!req_we) begin
                  state_d    = ST_READ;
                  mem_addr_d = req_addr;
               end else if (req_be == 4'hF) begin
                  state_d     = ST_WRITE;
                  mem_addr_d  = req_addr;
                  mem_wdata_d = req_wdata;
               end else if (req_be == 4'h0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d    = ST_MERGE;
                  mem_addr_d = req_addr;
               end
            end
         end
         ST_READ: begin
            if (win_q) b_rdata_d = memReadData;
            else       a_rdata_d = memReadData;
            state_d = ST_RESP;
         end
         ST_MERGE: begin
            mem_wdata_d = merged;
            state_d     = ST_WRITE;
         end
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 1'b0;
         win_q       <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         err_q       <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         err_q       <= err_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // memWrite is gated by reset so an abandoned store never reaches the array
   assign memRead      = (state_q == ST_READ) || (state_q == ST_MERGE);
   assign memWrite     = (state_q == ST_WRITE) && !reset;
   assign memAddress   = mem_addr_q;
   assign memWriteData = mem_wdata_q;
   assign aAck         = (state_q == ST_RESP) && !win_q;
   assign bAck         = (state_q == ST_RESP) && win_q;
   assign err          = (state_q == ST_RESP) && err_q;
   assign aRdata       = a_rdata_q;
   assign bRdata       = b_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected responses, a negedge monitor
// pops and compares on each ack; memory is modelled with combinational read and negedge write.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        aReq, aWe, bReq, bWe;
   logic [31:0] aAddr, aWdata, bAddr, bWdata;
   logic [3:0]  aBe, bBe;
   logic        aAck, bAck, err, memRead, memWrite;
   logic [31:0] aRdata, bRdata, memAddress, memWriteData, memReadData;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .reset(reset),
      .aReq(aReq), .aWe(aWe), .aAddr(aAddr), .aWdata(aWdata), .aBe(aBe),
      .aAck(aAck), .aRdata(aRdata),
      .bReq(bReq), .bWe(bWe), .bAddr(bAddr), .bWdata(bWdata), .bBe(bBe),
      .bAck(bAck), .bRdata(bRdata),
      .err(err), .memRead(memRead), .memWrite(memWrite),
      .memAddress(memAddress), .memWriteData(memWriteData),
      .memReadData(memReadData)
   );

   logic [31:0] mem [0:1023] = '{default: 32'h0};
   assign memReadData = mem[memAddress[11:2]];
   always @(negedge clk) if (memWrite) mem[memAddress[11:2]] <= memWriteData;

   typedef struct {
      bit          port;
      bit          is_load;
      logic [31:0] rdata;
      bit          err;
   } exp_t;
   exp_t sbq[$];

   int pass_cnt = 0;
   int total_cnt = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (memWrite) wr_cnt++;
      if (memRead)  rd_cnt++;
      if (memRead && memWrite) check("rd_wr_exclusive", 32'(memRead && memWrite), 32'd0);
      if (aAck || bAck) begin
         check("ack_exclusive", 32'(aAck && bAck), 32'd0);
         if (sbq.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("ack_port", 32'(bAck), 32'(e.port));
            check("ack_err", 32'(err), 32'(e.err));
            if (e.is_load) check("ack_rdata", e.port ? bRdata : aRdata, e.rdata);
         end
      end
   end

   task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (port) begin bReq = req; bWe = we; bAddr = addr; bWdata = wdata; bBe = be; end
      else      begin aReq = req; aWe = we; aAddr = addr; aWdata = wdata; aBe = be; end
   endtask

   // issue one transaction from the IDLE negedge; returns at the following IDLE negedge
   task automatic txn(input string name, input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_rd,
                      input bit exp_err, input int exp_lat, input int exp_wr, input int exp_rdc);
      exp_t e;
      int lat, wr0, rd0;
      bit got;
      e.port = port; e.is_load = !we; e.rdata = exp_rd; e.err = exp_err;
      sbq.push_back(e);
      wr0 = wr_cnt; rd0 = rd_cnt;
      drive(port, 1'b1, we, addr, wdata, be);
      lat = 0; got = 0;
      while (!got && lat < 20) begin
         @(posedge clk); lat++; #1;
         if (port ? bAck : aAck) got = 1;
      end
      drive(port, 1'b0, we, addr, wdata, be);
      check({name, "_ack_seen"}, 32'(got), 32'd1);
      check({name, "_latency"}, lat, exp_lat);
      @(negedge clk);
      @(negedge clk);
      check({name, "_memwrite_cycles"}, wr_cnt - wr0, exp_wr);
      check({name, "_memread_cycles"}, rd_cnt - rd0, exp_rdc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks, wr0;
      exp_t e;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(negedge clk);
      check("rst_aAck", 32'(aAck), 32'd0);
      check("rst_bAck", 32'(bAck), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_memRead", 32'(memRead), 32'd0);
      check("rst_memWrite", 32'(memWrite), 32'd0);
      check("rst_memAddress", memAddress, 32'h0);
      check("rst_memWriteData", memWriteData, 32'h0);
      check("rst_aRdata", aRdata, 32'h0);
      check("rst_bRdata", bRdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // full store then load on A
      txn("a_full_store", 1'b0, 1'b1, 32'h7FFFFFF0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 1, 0);
      txn("a_load", 1'b0, 1'b0, 32'h7FFFFFF0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1);
      repeat (3) @(negedge clk);
      check("a_rdata_hold", aRdata, 32'hDEADBEEF);

      // partial store by read-modify-write on B (low address bits must be ignored)
      txn("b_preload", 1'b1, 1'b1, 32'h7FFFFFF4, 32'h11223344, 4'hF, 32'h0, 1'b0, 2, 1, 0);
      txn("b_preload2", 1'b1, 1'b1, 32'h7FFFFFF8, 32'h01020304, 4'hF, 32'h0, 1'b0, 2, 1, 0);
      txn("b_partial", 1'b1, 1'b1, 32'h7FFFFFF7, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 3, 1, 1);
      txn("b_reload", 1'b1, 1'b0, 32'h7FFFFFF4, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 0, 1);
      check("a_rdata_hold_after_b", aRdata, 32'hDEADBEEF);

      // both requesters held: pointer is at A after the B grants
      for (int k = 0; k < 4; k++) begin
         e.port = k[0]; e.is_load = 1'b1; e.err = 1'b0;
         e.rdata = k[0] ? 32'h11BB33DD : 32'hDEADBEEF;
         sbq.push_back(e);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h7FFFFFF0, 32'h0, 4'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h7FFFFFF4, 32'h0, 4'h0);
      acks = 0;
      for (int c = 0; c < 60 && acks < 4; c++) begin
         @(posedge clk); #1;
         if (aAck || bAck) acks++;
      end
      aReq = 1'b0; bReq = 1'b0;
      check("arb_ack_count", acks, 4);
      @(negedge clk); @(negedge clk);
      check("arb_queue_drained", sbq.size(), 0);

      // be=0000 store: ack only, memory untouched
      txn("a_be0_store", 1'b0, 1'b1, 32'h7FFFFFF0, 32'h12345678, 4'h0, 32'h0, 1'b0, 1, 0, 0);
      txn("a_be0_reload", 1'b0, 1'b0, 32'h7FFFFFF0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1);

      // reset during WRITE abandons the store
      wr0 = wr_cnt;
      drive(1'b0, 1'b1, 1'b1, 32'h7FFFFFF8, 32'hCAFEF00D, 4'hF);
      @(posedge clk); #1;
      check("rst_mid_in_write", 32'(memAddress), 32'h7FFFFFF8);
      reset = 1'b1;
      aReq = 1'b0;
      @(negedge clk);
      check("rst_mid_memWrite", 32'(memWrite), 32'd0);
      check("rst_mid_aAck", 32'(aAck), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_write_count", wr_cnt - wr0, 0);
      txn("rst_reload", 1'b0, 1'b0, 32'h7FFFFFF8, 32'h0, 4'h0, 32'h01020304, 1'b0, 2, 0, 1);

      // out-of-window load
`ifdef MEM_CTRL_RANGE_CHECK_EN
      txn("range_load", 1'b0, 1'b0, 32'h00000010, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 0);
`else
      txn("range_load", 1'b0, 1'b0, 32'h00000010, 32'h0, 4'h0, 32'h0, 1'b0, 2, 0, 1);
`endif
      txn("inrange_load", 1'b0, 1'b0, 32'h7FFFFFF4, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 0, 1);

      repeat (2) @(negedge clk);
      check("final_queue_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
